// File: rtl/alu_mem_master.sv
// alu_mem_master: bus initiator for the register-mapped ALU slave.
// It accepts one command (A, B, OP) on a valid/ready port and writes the three
// values to slave registers 0, 1 and 2. It then polls STATUS (register 3) until
// bit0 reads back as done, or until POLL_MAX reads have gone by. The captured
// res_out (or a timeout error) is returned on a valid/ready response port.
//
// Ports:
//   clk, reset            : clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake; cmd_ready is high only in IDLE
//   cmd_a/cmd_b/cmd_op    : operands and opcode, latched at acceptance
//   rsp_valid/rsp_ready   : response handshake
//   rsp_result/rsp_err    : captured res_out, or 0 with err=1 on poll timeout
//   addr/wr_data/rd_wr    : slave bus (rd_wr: 0 = write, 1 = read)
//   enable                : one-cycle strobe per bus access
//   rd_data/res_out       : slave read data and ALU result
module alu_mem_master #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8,
  parameter int RES_WIDTH  = 16,
  parameter int RD_LATENCY = 1,
  parameter int POLL_MAX   = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  input  logic [DATA_WIDTH-1:0] cmd_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [RES_WIDTH-1:0]  rsp_result,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_wr,
  output logic                  enable,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [RES_WIDTH-1:0]  res_out
);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, WR_OP, RD_REQ, RD_WAIT, RESP} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_A      = ADDR_WIDTH'(0);
  localparam logic [ADDR_WIDTH-1:0] ADDR_B      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_OP     = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS = ADDR_WIDTH'(3);
  localparam logic [2:0]            WAIT_LAST   = 3'(RD_LATENCY - 1);
  localparam logic [15:0]           POLL_LIMIT  = 16'(POLL_MAX);

  state_t                  state_q, state_d;
  logic                    enable_q, enable_d;
  logic                    rd_wr_q, rd_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [RES_WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [15:0]             poll_q, poll_d;
  logic [2:0]              wait_q, wait_d;
  logic [DATA_WIDTH-1:0]   a_q, a_d, b_q, b_d, op_q, op_d;

  // Only bit0 (done) of STATUS carries meaning; the upper bits are reserved.
  logic [DATA_WIDTH-1:0]   status_unused;
  assign status_unused = rd_data;

  always_comb begin
    state_d      = state_q;
    enable_d     = enable_q;
    rd_wr_d      = rd_wr_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    poll_d       = poll_q;
    wait_d       = wait_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    // Bus outputs are registered, so each state prepares the access that the
    // following state presents on the bus.
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          a_d       = cmd_a;
          b_d       = cmd_b;
          op_d      = cmd_op;
          poll_d    = '0;
          state_d   = WR_A;
          enable_d  = 1'b1;
          rd_wr_d   = 1'b0;
          addr_d    = ADDR_A;
          wr_data_d = cmd_a;
        end
      end
      WR_A: begin
        state_d   = WR_B;
        addr_d    = ADDR_B;
        wr_data_d = b_q;
      end
      WR_B: begin
        state_d   = WR_OP;
        addr_d    = ADDR_OP;
        wr_data_d = op_q;
      end
      WR_OP: begin
        state_d = RD_REQ;
        rd_wr_d = 1'b1;
        addr_d  = ADDR_STATUS;
      end
      RD_REQ: begin
        state_d  = RD_WAIT;
        enable_d = 1'b0;
        poll_d   = poll_q + 16'd1;
        wait_d   = '0;
      end
      RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          if (rd_data[0]) begin
            rsp_result_d = res_out;
            rsp_err_d    = 1'b0;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end else if (poll_q == POLL_LIMIT) begin
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            rsp_valid_d  = 1'b1;
            state_d      = RESP;
          end else begin
            state_d  = RD_REQ;
            enable_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      enable_q     <= 1'b0;
      rd_wr_q      <= 1'b1;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      poll_q       <= '0;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      enable_q     <= enable_d;
      rd_wr_q      <= rd_wr_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      poll_q       <= poll_d;
      wait_q       <= wait_d;
    end
  end

  // Latched command copies are only meaningful after acceptance.
  always_ff @(posedge clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign cmd_ready  = (state_q == IDLE);
  assign enable     = enable_q;
  assign rd_wr      = rd_wr_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_mem_master.sv
// Bench for alu_mem_master: instance 0 (RD_LATENCY=1, POLL_MAX=255) and
// instance 1 (RD_LATENCY=3, POLL_MAX=3) share one behavioural slave, selected by sel.
module tb_alu_mem_master;

  typedef struct packed {
    logic        err;
    logic [15:0] res;
    logic [31:0] lat;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, rsp_ready, sel;
  logic [7:0]  cmd_a, cmd_b, cmd_op;
  logic        cv0, cv1;
  logic        cmd_ready0, rsp_valid0, rsp_err0, rd_wr0, enable0;
  logic        cmd_ready1, rsp_valid1, rsp_err1, rd_wr1, enable1;
  logic [15:0] rsp_result0, rsp_result1;
  logic [1:0]  addr0, addr1;
  logic [7:0]  wr_data0, wr_data1;
  logic [7:0]  rd_data;
  logic [15:0] res_out;

  logic        m_en, m_rdwr, m_cmd_ready, m_rsp_valid, m_err;
  logic [1:0]  m_addr;
  logic [7:0]  m_wdata;
  logic [15:0] m_res;

  assign cv0 = cmd_valid & ~sel;
  assign cv1 = cmd_valid & sel;
  assign m_en        = sel ? enable1     : enable0;
  assign m_rdwr      = sel ? rd_wr1      : rd_wr0;
  assign m_addr      = sel ? addr1       : addr0;
  assign m_wdata     = sel ? wr_data1    : wr_data0;
  assign m_cmd_ready = sel ? cmd_ready1  : cmd_ready0;
  assign m_rsp_valid = sel ? rsp_valid1  : rsp_valid0;
  assign m_err       = sel ? rsp_err1    : rsp_err0;
  assign m_res       = sel ? rsp_result1 : rsp_result0;

  alu_mem_master #(.RD_LATENCY(1), .POLL_MAX(255)) u_dut0 (
    .clk(clk), .reset(rst_n), .cmd_valid(cv0), .cmd_ready(cmd_ready0),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid0),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result0), .rsp_err(rsp_err0),
    .addr(addr0), .wr_data(wr_data0), .rd_wr(rd_wr0), .enable(enable0),
    .rd_data(rd_data), .res_out(res_out)
  );

  alu_mem_master #(.RD_LATENCY(3), .POLL_MAX(3)) u_dut1 (
    .clk(clk), .reset(rst_n), .cmd_valid(cv1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .rsp_valid(rsp_valid1),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result1), .rsp_err(rsp_err1),
    .addr(addr1), .wr_data(wr_data1), .rd_wr(rd_wr1), .enable(enable1),
    .rd_data(rd_data), .res_out(res_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model and bus monitor state
  logic [9:0]  wr_log[$];
  logic [9:0]  exp_wr[$];
  rsp_t        rsp_log[$];
  rsp_t        exp_q[$];
  int          n_rdreq = 0, n_acc = 0, n_en_rsp = 0;
  int          acc_cyc = 0, rise_lat = 0, polls = 0, done_at = 1;
  bit          rsp_seen = 0, glitch = 0;
  logic [15:0] res_val = 16'h0;
  logic        done_flag = 1'b0;
  logic [2:0]  rhist = 3'b0, dhist = 3'b0;

  // Status bit0 appears RD_LATENCY cycles after the read strobe; with glitch set,
  // instance 1 also sees a false done one cycle early.
  assign rd_data = {7'b0, sel ? ((rhist[2] & dhist[2]) | (glitch & rhist[1]))
                              : (rhist[0] & dhist[0])};
  assign res_out = done_flag ? res_val : 16'hDEAD;

  always @(posedge clk) begin : slave_mon
    logic st_rd, dn;
    st_rd = m_en && m_rdwr && (m_addr == 2'd3);
    dn    = st_rd && (done_at != 0) && (polls + 1 >= done_at);
    if (m_en && !m_rdwr) begin
      wr_log.push_back({m_addr, m_wdata});
      if (m_addr == 2'd2) begin
        polls = 0;
        done_flag <= 1'b0;
      end
    end
    if (st_rd) begin
      polls   = polls + 1;
      n_rdreq = n_rdreq + 1;
      if (dn) done_flag <= 1'b1;
    end
    rhist <= {rhist[1:0], st_rd};
    dhist <= {dhist[1:0], dn};
    if (cmd_valid && m_cmd_ready) begin
      acc_cyc = cyc;
      n_acc   = n_acc + 1;
    end
    if (m_rsp_valid && !rsp_seen) begin
      rise_lat = cyc - acc_cyc;
      rsp_seen = 1;
    end
    if (m_rsp_valid && m_en) n_en_rsp = n_en_rsp + 1;
    if (m_rsp_valid && rsp_ready) begin
      rsp_log.push_back({m_err, m_res, 32'(rise_lat)});
      rsp_seen = 0;
    end
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] a, b, op, input logic err,
                          input logic [15:0] res, input int lat);
    exp_wr.push_back({2'd0, a});
    exp_wr.push_back({2'd1, b});
    exp_wr.push_back({2'd2, op});
    exp_q.push_back({err, res, 32'(lat)});
  endtask

  task automatic send(input logic [7:0] a, b, op, input logic err,
                      input logic [15:0] res, input int lat, input string tag);
    int s;
    push_exp(a, b, op, err, res, lat);
    cmd_a = a; cmd_b = b; cmd_op = op;
    cmd_valid = 1'b1;
    s = n_acc;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (n_acc != s) break;
    end
    cmd_valid = 1'b0;
    // Scramble inputs so only latched copies can produce the right writes.
    cmd_a = ~a; cmd_b = ~b; cmd_op = ~op;
    chk({tag, "_accept"}, n_acc - s, 1);
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e, o;
    int k;
    e = exp_q.pop_front();
    k = 0;
    while (rsp_log.size() == 0 && k < 400) begin
      tick();
      k++;
    end
    if (rsp_log.size() == 0) begin
      chk({tag, "_rsp_timeout"}, 0, 1);
    end else begin
      o = rsp_log.pop_front();
      chk({tag, "_err"}, 32'(o.err), 32'(e.err));
      chk({tag, "_result"}, 32'(o.res), 32'(e.res));
      chk({tag, "_latency"}, o.lat, e.lat);
    end
  endtask

  task automatic check_writes(input string tag);
    logic [9:0] e, o;
    for (int k = 0; k < 3; k++) begin
      e = exp_wr.pop_front();
      o = (wr_log.size() > 0) ? wr_log.pop_front() : 10'h3FF;
      chk($sformatf("%s_write%0d", tag, k), 32'(o), 32'(e));
    end
  endtask

  task automatic run_cmd(input logic [7:0] a, b, op, input logic err,
                         input logic [15:0] res, input int lat, input int reqs,
                         input string tag);
    int r0;
    r0 = n_rdreq;
    send(a, b, op, err, res, lat, tag);
    check_rsp(tag);
    check_writes(tag);
    chk({tag, "_rdreq"}, n_rdreq - r0, reqs);
  endtask

  initial begin
    int s, k;
    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1; sel = 1'b0;
    cmd_a = 8'h0; cmd_b = 8'h0; cmd_op = 8'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready0), 1);
    chk("rst_enable", 32'(enable0), 0);
    chk("rst_rd_wr", 32'(rd_wr0), 1);
    chk("rst_addr", 32'(addr0), 0);
    chk("rst_wr_data", 32'(wr_data0), 0);
    chk("rst_rsp_valid", 32'(rsp_valid0), 0);
    chk("rst_rsp_result", 32'(rsp_result0), 0);
    chk("rst_rsp_err", 32'(rsp_err0), 0);
    chk("rst_enable1", 32'(enable1), 0);
    rst_n = 1'b1;
    tick();

    // Basic: done on first poll
    done_at = 1; res_val = 16'h0046;
    run_cmd(8'h12, 8'h34, 8'h01, 1'b0, 16'h0046, 6, 1, "basic");

    // Slow slave: done on 4th poll
    done_at = 4; res_val = 16'hBEEF;
    run_cmd(8'hA5, 8'h5A, 8'h02, 1'b0, 16'hBEEF, 12, 4, "slow");

    // Backpressure, then a second command held pending
    done_at = 1; res_val = 16'h1234; rsp_ready = 1'b0;
    send(8'h11, 8'h22, 8'h03, 1'b0, 16'h1234, 6, "bp1");
    cmd_a = 8'h55; cmd_b = 8'h66; cmd_op = 8'h07; cmd_valid = 1'b1;
    s = n_acc;
    k = 0;
    while (!m_rsp_valid && k < 50) begin
      tick();
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_valid_c%0d", c), 32'(m_rsp_valid), 1);
      chk($sformatf("bp_result_c%0d", c), 32'(m_res), 32'h1234);
      chk($sformatf("bp_err_c%0d", c), 32'(m_err), 0);
      chk($sformatf("bp_enable_c%0d", c), 32'(m_en), 0);
      chk($sformatf("bp_cmd_ready_c%0d", c), 32'(m_cmd_ready), 0);
      tick();
    end
    push_exp(8'h55, 8'h66, 8'h07, 1'b0, 16'h00AA, 6);
    rsp_ready = 1'b1;
    tick();
    chk("hs_rsp_valid_low", 32'(m_rsp_valid), 0);
    chk("hs_cmd_ready", 32'(m_cmd_ready), 1);
    chk("hs_not_yet_accepted", n_acc - s, 0);
    res_val = 16'h00AA;
    tick();
    chk("b2b_accepted", n_acc - s, 1);
    cmd_valid = 1'b0; cmd_a = 8'h0; cmd_b = 8'h0; cmd_op = 8'h0;
    check_rsp("bp1");
    check_writes("bp1");
    check_rsp("b2b");
    check_writes("b2b");

    // Reset asserted during WR_B
    done_at = 1; res_val = 16'h0077;
    cmd_a = 8'h99; cmd_b = 8'h88; cmd_op = 8'h06; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("mid_in_wr_b", 32'(m_addr), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_enable", 32'(enable0), 0);
    chk("mid_rst_rsp_valid", 32'(rsp_valid0), 0);
    chk("mid_rst_cmd_ready", 32'(cmd_ready0), 1);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("mid_rst_no_rsp", rsp_log.size(), 0);
    chk("mid_rst_rsp_valid_later", 32'(m_rsp_valid), 0);
    wr_log.delete();
    run_cmd(8'h0F, 8'hF0, 8'h04, 1'b0, 16'h0077, 6, 1, "post_rst");

    // Instance 1: timeout after 3 polls
    sel = 1'b1; done_at = 0; res_val = 16'h5555;
    tick();
    run_cmd(8'h01, 8'h02, 8'h03, 1'b1, 16'h0000, 16, 3, "timeout");

    // Instance 1: early false done ignored, real done on 2nd poll
    glitch = 1; done_at = 2; res_val = 16'hC0DE;
    run_cmd(8'h21, 8'h43, 8'h05, 1'b0, 16'hC0DE, 12, 2, "lat3");
    glitch = 0;

    chk("enable_during_rsp", n_en_rsp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
